// File: rtl/product_integrator_if.sv
// Stream and result bundle between the mixer, the integrator
// and the I/Q readout logic.
interface product_integrator_if #(
   parameter int PRODUCT_W = 32,
   parameter int ACC_W     = 48,
   parameter int LEN_W     = 16
);
   logic                 trigger;
   logic [LEN_W-1:0]     length_in;
   logic                 write_enable_in;
   logic [PRODUCT_W-1:0] product_in;
   logic [ACC_W-1:0]     sum_out;
   logic                 sum_valid;
   logic                 overflow;
   logic                 busy;

   modport master (
      output trigger,
      output length_in,
      output write_enable_in,
      output product_in,
      input  sum_out,
      input  sum_valid,
      input  overflow,
      input  busy
   );

   modport slave (
      input  trigger,
      input  length_in,
      input  write_enable_in,
      input  product_in,
      output sum_out,
      output sum_valid,
      output overflow,
      output busy
   );
endinterface

// File: rtl/product_integrator.sv
// Triggered boxcar integrator of signed mixer products with
// saturating accumulation and a sticky per-window overflow flag.
module product_integrator #(
   parameter int PRODUCT_W = 32,
   parameter int ACC_W     = 48,
   parameter int LEN_W     = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   product_integrator_if.slave  bus
);

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX =
      {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN =
      {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_int_q, ovf_int_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             valid_q, valid_d;
   logic             ovf_out_q, ovf_out_d;

   logic [ACC_W:0]   sum_ext;
   logic             sat_hi;
   logic             sat_lo;
   logic [ACC_W-1:0] acc_sat;
   logic [LEN_W-1:0] count_inc;

   // One guard bit detects signed overflow of the add.
   assign sum_ext = {acc_q[ACC_W-1], acc_q}
      + {{(ACC_W+1-PRODUCT_W){bus.product_in[PRODUCT_W-1]}},
         bus.product_in};
   assign sat_hi = !sum_ext[ACC_W] && sum_ext[ACC_W-1];
   assign sat_lo = sum_ext[ACC_W] && !sum_ext[ACC_W-1];
   assign acc_sat = sat_hi ? ACC_MAX :
                    sat_lo ? ACC_MIN :
                    sum_ext[ACC_W-1:0];
   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      count_d   = count_q;
      acc_d     = acc_q;
      ovf_int_d = ovf_int_q;
      sum_d     = sum_q;
      valid_d   = 1'b0;
      ovf_out_d = ovf_out_q;
      unique case (state_q)
         IDLE: begin
            if (bus.trigger && (bus.length_in != '0)) begin
               len_d     = bus.length_in;
               acc_d     = '0;
               count_d   = '0;
               ovf_int_d = 1'b0;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.write_enable_in) begin
               acc_d     = acc_sat;
               ovf_int_d = ovf_int_q | sat_hi | sat_lo;
               count_d   = count_inc;
               if (count_inc == len_q) begin
                  sum_d     = acc_sat;
                  ovf_out_d = ovf_int_q | sat_hi | sat_lo;
                  valid_d   = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         count_q   <= '0;
         acc_q     <= '0;
         ovf_int_q <= 1'b0;
         sum_q     <= '0;
         valid_q   <= 1'b0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         ovf_int_q <= ovf_int_d;
         sum_q     <= sum_d;
         valid_q   <= valid_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   assign bus.sum_out   = sum_q;
   assign bus.sum_valid = valid_q;
   assign bus.overflow  = ovf_out_q;
   assign bus.busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_product_integrator.sv
// Directed bench for product_integrator with a 36-bit accumulator
// so a 32-sample window of full-scale products saturates.
module tb_product_integrator;

   localparam int PW = 32;
   localparam int AW = 36;
   localparam int LW = 16;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   product_integrator_if #(
      .PRODUCT_W(PW), .ACC_W(AW), .LEN_W(LW)
   ) bus ();

   product_integrator #(
      .PRODUCT_W(PW), .ACC_W(AW), .LEN_W(LW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string              tag,
      input logic signed [63:0] got,
      input logic signed [63:0] exp
   );
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d",
                    tag, got, exp);
   endtask

   // Drive one cycle of inputs at the falling edge; outputs
   // seen here reflect the preceding rising edge.
   task automatic cyc(
      input logic          t,
      input logic [LW-1:0] l,
      input logic          w,
      input logic [PW-1:0] p
   );
      @(negedge clk);
      bus.trigger         = t;
      bus.length_in       = l;
      bus.write_enable_in = w;
      bus.product_in      = p;
   endtask

   task automatic chk_out(
      input string              tag,
      input logic signed [63:0] sum,
      input logic               vld,
      input logic               ovf,
      input logic               bsy
   );
      chk({tag, ".sum"}, $signed(bus.sum_out), sum);
      chk({tag, ".valid"}, bus.sum_valid, vld);
      chk({tag, ".ovf"}, bus.overflow, ovf);
      chk({tag, ".busy"}, bus.busy, bsy);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus.trigger         = 1'b0;
      bus.length_in       = '0;
      bus.write_enable_in = 1'b0;
      bus.product_in      = '0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk_out("reset", 0, 0, 0, 0);
      rst_n = 1'b1;

      // 1: plain window of four
      cyc(1, 4, 0, 0);
      cyc(0, 0, 1, 1);
      chk("t1.busy", bus.busy, 1);
      cyc(0, 0, 1, 2);
      cyc(0, 0, 1, 3);
      cyc(0, 0, 1, 4);
      chk("t1.early", bus.sum_valid, 0);
      cyc(0, 0, 0, 0);
      chk_out("t1", 10, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t1.pulse", bus.sum_valid, 0);

      // 2: write-enable gaps stall the window
      cyc(1, 3, 0, 0);
      cyc(0, 0, 1, -5);
      cyc(0, 0, 0, 77);
      cyc(0, 0, 0, 77);
      chk("t2.gap_busy", bus.busy, 1);
      chk("t2.gap_vld", bus.sum_valid, 0);
      cyc(0, 0, 1, 7);
      cyc(0, 0, 1, -100);
      cyc(0, 0, 0, 0);
      chk_out("t2", -98, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk_out("t2.after", -98, 0, 0, 0);

      // 3: trigger-cycle product is excluded
      cyc(1, 2, 1, 1000);
      cyc(0, 0, 1, 2);
      cyc(0, 0, 1, 2);
      cyc(0, 0, 0, 0);
      chk_out("t3", 4, 1, 0, 0);

      // 4: saturation and flag reset on next window
      cyc(1, 32, 0, 0);
      for (int i = 0; i < 32; i++) cyc(0, 0, 1, 32'h7FFF_FFFF);
      cyc(0, 0, 0, 0);
      chk_out("t4.sat", 64'h7_FFFF_FFFF, 1, 1, 0);
      cyc(0, 0, 0, 0);
      chk("t4.hold_ovf", bus.overflow, 1);
      cyc(1, 1, 0, 0);
      cyc(0, 0, 1, 32'hFFFF_FFFF);
      cyc(0, 0, 0, 0);
      chk_out("t4.next", -1, 1, 0, 0);

      // 5: reset mid-window aborts it
      cyc(1, 5, 0, 0);
      cyc(0, 0, 1, 3);
      cyc(0, 0, 1, 4);
      cyc(0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      chk_out("t5.rst", 0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);
      chk_out("t5.idle", 0, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 0, 1, 9);
      cyc(0, 0, 0, 0);
      chk_out("t5", 9, 1, 0, 0);

      // 6: ignored triggers, back-to-back window
      cyc(1, 2, 0, 0);
      cyc(0, 0, 1, 5);
      cyc(1, 7, 1, 6);
      cyc(1, 1, 0, 0);
      chk_out("t6.a", 11, 1, 0, 0);
      cyc(0, 0, 1, 20);
      chk("t6.b2b_busy", bus.busy, 1);
      cyc(0, 0, 0, 0);
      chk_out("t6.b", 20, 1, 0, 0);
      cyc(1, 0, 1, 50);
      cyc(0, 0, 1, 50);
      chk("t6.len0_busy", bus.busy, 0);
      cyc(0, 0, 0, 0);
      chk_out("t6.len0", 20, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
